// File: rtl/clock_domain_pkg.sv
// Shared constants for the toggle req/ack clock-domain-crossing pair
// (exporter and importer).
package clock_domain_pkg;

  // Flop stages on the incoming req toggle.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of the optional imported-word counter.
  localparam int unsigned CDC_COUNT_W = 16;

  // FIFO pointer width: address bits plus one wrap bit.
  function automatic int unsigned cdc_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/clock_domain_import_fifo.sv
// Synchronous FIFO for the importer. The head word is combinational.
// Storage is not reset. rdata reads as zero while the FIFO is empty.
module clock_domain_import_fifo
  import clock_domain_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PW = cdc_ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [SIZE-1:0] mem_q [DEPTH];
  logic            do_push, do_pop;

  // Flags and next pointers. The extra MSB tells full apart from empty.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;
    rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage. Not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/clock_domain_import.sv
// Destination half of the toggle req/ack CDC handshake.
// The req toggle is synchronised, the word is captured into a local FIFO,
// and the ack is then returned. The ack is withheld while the FIFO is full.
// Optional feature: define CLOCK_DOMAIN_IMPORT_COUNT_EN to add the word_count output.
module clock_domain_import
  import clock_domain_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SIZE-1:0]        handshake_data,
  input  logic                   handshake_req,
  output logic                   handshake_ack,
  output logic [SIZE-1:0]        data,
  output logic                   stb,
  input  logic                   ready
`ifdef CLOCK_DOMAIN_IMPORT_COUNT_EN
  ,
  output logic [CDC_COUNT_W-1:0] word_count
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic                   req_x2;
  logic                   push, pop, full, empty;

  // Synchroniser shift and capture decision. Only the last stage is used.
  // Full comes from registered pointers, so a pop does not free a slot until the next cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], handshake_req};
    req_x2 = sync_q[SYNC_STAGES-1];
    push   = (req_x2 != ack_q) && !full;
    pop    = stb && ready;
    ack_d  = push ? req_x2 : ack_q;
    stb    = !empty;
  end

  // Synchroniser and ack registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ack_q  <= ack_d;
    end
  end

  assign handshake_ack = ack_q;

  clock_domain_import_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (handshake_data),
    .rdata (data),
    .full  (full),
    .empty (empty)
  );

`ifdef CLOCK_DOMAIN_IMPORT_COUNT_EN
  logic [CDC_COUNT_W-1:0] count_q, count_d;

  // Count of captured words. Wraps naturally.
  always_comb begin
    count_d = push ? count_q + CDC_COUNT_W'(1) : count_q;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign word_count = count_q;
`endif

endmodule
